// File: rtl/pellet_store_if.sv
// Eat/init handshake between the scoring FSM (master) and the pellet store (slave).
interface pellet_store_if;
    logic       init_start;
    logic       init_done;
    logic       eat_req;
    logic [9:0] eat_x;
    logic [9:0] eat_y;
    logic       eat_ack;
    logic       eat_hit;
    logic [8:0] remaining;
    logic       all_eaten;

    modport master (
        output init_start, eat_req, eat_x, eat_y,
        input  init_done, eat_ack, eat_hit, remaining, all_eaten
    );

    modport slave (
        input  init_start, eat_req, eat_x, eat_y,
        output init_done, eat_ack, eat_hit, remaining, all_eaten
    );
endinterface

// File: rtl/pellet_store.sv
// Pellet bitmap owner: loads the layout row by row, serves eat requests with hit/miss,
// counts pellets left and renders a registered pellet-dot pixel for the VGA path.
module pellet_store #(
    parameter int                     COLS        = 20,
    parameter int                     ROWS        = 15,
    parameter int                     TILE_LOG2   = 5,
    parameter int                     DOT         = 4,
    parameter logic [COLS*ROWS-1:0]   PELLET_MASK = {(COLS*ROWS){1'b1}},
    parameter logic [11:0]            PELLET_RGB  = 12'hFF0
) (
    input  logic                clk,
    input  logic                reset,
    pellet_store_if.slave       bus,
    input  logic [9:0]          hCount,
    input  logic [9:0]          vCount,
    input  logic                bright,
    output logic                pellet_pixel,
    output logic [11:0]         rgb
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [9:0] COLS_LIM = 10'(COLS);
    localparam logic [9:0] ROWS_LIM = 10'(ROWS);
    localparam logic [TILE_LOG2-1:0] DOT_LO = TILE_LOG2'(2**(TILE_LOG2-1) - DOT/2);
    localparam logic [TILE_LOG2-1:0] DOT_HI = TILE_LOG2'(2**(TILE_LOG2-1) + DOT/2);

    typedef enum logic [1:0] {EMPTY, INIT, READY} state_t;

    state_t          state;
    logic [RW-1:0]   row_cnt;
    logic [COLS-1:0] bitmap [ROWS];

    function automatic logic [8:0] row_pop(input logic [COLS-1:0] bits);
        logic [8:0] count;
        count = '0;
        for (int i = 0; i < COLS; i++) count = count + 9'(bits[i]);
        return count;
    endfunction

    logic [COLS-1:0] mask_slice;
    assign mask_slice = PELLET_MASK[int'(row_cnt)*COLS +: COLS];

    // Eat request decode: tile coordinates and the current bit under them.
    logic [9:0] eat_col, eat_row;
    logic       eat_in_range, eat_bit;
    assign eat_col      = bus.eat_x >> TILE_LOG2;
    assign eat_row      = bus.eat_y >> TILE_LOG2;
    assign eat_in_range = (eat_col < COLS_LIM) && (eat_row < ROWS_LIM);
    assign eat_bit      = eat_in_range && bitmap[eat_row[RW-1:0]][eat_col[CW-1:0]];

    assign bus.all_eaten = (state == READY) && (bus.remaining == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= EMPTY;
            row_cnt       <= '0;
            bus.init_done <= 1'b0;
            bus.eat_ack   <= 1'b0;
            bus.eat_hit   <= 1'b0;
            bus.remaining <= '0;
            // NOTE: the bitmap is reset so a reset mid-load never leaves stale pellets drawn or eatable.
            bitmap        <= '{default: '0};
        end else begin
            bus.init_done <= 1'b0;
            bus.eat_ack   <= 1'b0;
            bus.eat_hit   <= 1'b0;
            case (state)
                EMPTY: begin
                    if (bus.init_start) begin
                        state         <= INIT;
                        row_cnt       <= '0;
                        bus.remaining <= '0;
                    end
                end
                INIT: begin
                    bitmap[row_cnt] <= mask_slice;
                    bus.remaining   <= bus.remaining + row_pop(mask_slice);
                    row_cnt         <= row_cnt + 1'b1;
                    if (row_cnt == RW'(ROWS-1)) begin
                        state         <= READY;
                        bus.init_done <= 1'b1;
                    end
                end
                READY: begin
                    // A reload takes priority over an eat presented in the same cycle.
                    if (bus.init_start) begin
                        state         <= INIT;
                        row_cnt       <= '0;
                        bus.remaining <= '0;
                    end else if (bus.eat_req && !bus.eat_ack) begin
                        bus.eat_ack <= 1'b1;
                        if (eat_bit) begin
                            bus.eat_hit <= 1'b1;
                            bitmap[eat_row[RW-1:0]][eat_col[CW-1:0]] <= 1'b0;
                            bus.remaining <= bus.remaining - 1'b1;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Render: dot is a DOT x DOT square centred in each tile holding a live pellet.
    logic [9:0]           pix_col, pix_row;
    logic [TILE_LOG2-1:0] off_x, off_y;
    logic                 pix_in_range, pix_bit, in_dot, dot_on;
    assign pix_col      = hCount >> TILE_LOG2;
    assign pix_row      = vCount >> TILE_LOG2;
    assign off_x        = hCount[TILE_LOG2-1:0];
    assign off_y        = vCount[TILE_LOG2-1:0];
    assign pix_in_range = (pix_col < COLS_LIM) && (pix_row < ROWS_LIM);
    assign pix_bit      = pix_in_range && bitmap[pix_row[RW-1:0]][pix_col[CW-1:0]];
    assign in_dot       = (off_x >= DOT_LO) && (off_x < DOT_HI) &&
                          (off_y >= DOT_LO) && (off_y < DOT_HI);
    assign dot_on       = bright && pix_bit && in_dot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pellet_pixel <= 1'b0;
            rgb          <= '0;
        end else begin
            pellet_pixel <= dot_on;
            rgb          <= dot_on ? PELLET_RGB : '0;
        end
    end

endmodule

// File: tb/tb_pellet_store.sv
// Scoreboard bench for pellet_store: a full-layout instance and a 3-pellet instance
// share stimulus; sel routes the handshake to one of them.
module tb_pellet_store;

    localparam logic [299:0] MASK3 = (300'd1 << 0) | (300'd1 << 65) | (300'd1 << 299);

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       init_start, eat_req, bright;
    logic [9:0] eat_x, eat_y, hCount, vCount;

    always #5 clk = ~clk;

    pellet_store_if bus0 ();
    pellet_store_if bus1 ();

    assign bus0.init_start = init_start & ~sel;
    assign bus1.init_start = init_start &  sel;
    assign bus0.eat_req    = eat_req & ~sel;
    assign bus1.eat_req    = eat_req &  sel;
    assign bus0.eat_x      = eat_x;
    assign bus1.eat_x      = eat_x;
    assign bus0.eat_y      = eat_y;
    assign bus1.eat_y      = eat_y;

    logic        pellet_pixel0, pellet_pixel1;
    logic [11:0] rgb0, rgb1;

    pellet_store u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .hCount(hCount), .vCount(vCount), .bright(bright),
        .pellet_pixel(pellet_pixel0), .rgb(rgb0)
    );

    pellet_store #(.PELLET_MASK(MASK3)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .hCount(hCount), .vCount(vCount), .bright(bright),
        .pellet_pixel(pellet_pixel1), .rgb(rgb1)
    );

    wire       init_done = sel ? bus1.init_done : bus0.init_done;
    wire       eat_ack   = sel ? bus1.eat_ack   : bus0.eat_ack;
    wire       eat_hit   = sel ? bus1.eat_hit   : bus0.eat_hit;
    wire [8:0] remaining = sel ? bus1.remaining : bus0.remaining;
    wire       all_eaten = sel ? bus1.all_eaten : bus0.all_eaten;

    typedef struct packed {
        logic       hit;
        logic [8:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [8:0] exp_rem, input logic exp_all);
        int n;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles, expected 15", n);
        end
        checks++;
        if (remaining !== exp_rem) begin
            errors++;
            $display("FAIL init_remaining: got %0d, expected %0d", remaining, exp_rem);
        end
        checks++;
        if (all_eaten !== exp_all) begin
            errors++;
            $display("FAIL init_all_eaten: got %b, expected %b", all_eaten, exp_all);
        end
        tick();
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_pulse: still %b one cycle later, expected 0", init_done);
        end
    endtask

    task automatic do_eat(input logic [9:0] x, input logic [9:0] y,
                          input logic hit, input logic [8:0] rem);
        int   n;
        exp_t e;
        exp_q.push_back('{hit: hit, rem: rem});
        eat_x   = x;
        eat_y   = y;
        eat_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!eat_ack && n < 20);
        eat_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!eat_ack) begin
            errors++;
            $display("FAIL eat_ack_timeout (%0d,%0d): no ack in %0d cycles, expected 1", x, y, n);
        end else begin
            checks++;
            if (n !== 1) begin
                errors++;
                $display("FAIL eat_latency (%0d,%0d): got %0d, expected 1", x, y, n);
            end
            checks++;
            if (eat_hit !== e.hit) begin
                errors++;
                $display("FAIL eat_hit (%0d,%0d): got %b, expected %b", x, y, eat_hit, e.hit);
            end
            checks++;
            if (remaining !== e.rem) begin
                errors++;
                $display("FAIL eat_remaining (%0d,%0d): got %0d, expected %0d", x, y, remaining, e.rem);
            end
            tick();
            checks++;
            if (eat_ack !== 1'b0) begin
                errors++;
                $display("FAIL eat_ack_pulse (%0d,%0d): got %b, expected 0", x, y, eat_ack);
            end
        end
    endtask

    // Eat request already held while a load runs: ack must follow init_done by one cycle.
    task automatic wait_init_then_ack(input string tag);
        int         n, n_done, n_ack;
        logic [8:0] done_rem, ack_rem;
        logic       ack_hit;
        exp_t       e;
        n = 0; n_done = -1; n_ack = -1;
        done_rem = 'x; ack_rem = 'x; ack_hit = 'x;
        while (n_ack < 0 && n < 60) begin
            tick();
            n++;
            if (init_done) begin
                n_done   = n;
                done_rem = remaining;
            end
            if (eat_ack) begin
                n_ack   = n;
                ack_hit = eat_hit;
                ack_rem = remaining;
            end
        end
        eat_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (n_done < 0 || done_rem !== 9'd300) begin
            errors++;
            $display("FAIL %s_reload: done at cycle %0d remaining %0d, expected done with 300", tag, n_done, done_rem);
        end
        checks++;
        if (n_ack < 0 || n_ack !== n_done + 1) begin
            errors++;
            $display("FAIL %s_ack_timing: ack at cycle %0d, expected %0d", tag, n_ack, n_done + 1);
        end
        checks++;
        if (ack_hit !== e.hit) begin
            errors++;
            $display("FAIL %s_hit: got %b, expected %b", tag, ack_hit, e.hit);
        end
        checks++;
        if (ack_rem !== e.rem) begin
            errors++;
            $display("FAIL %s_remaining: got %0d, expected %0d", tag, ack_rem, e.rem);
        end
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [31:0] got;
        got = {bus0.init_done, bus0.eat_ack, bus0.eat_hit, bus0.remaining, bus0.all_eaten,
               bus1.remaining, bus1.all_eaten, pellet_pixel0, rgb0};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s_outputs: got %h, expected 0", tag, got);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        eat_x = 10'd40; eat_y = 10'd70; eat_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (eat_ack !== 1'b0) begin
                errors++;
                $display("FAIL empty_eat_ack: got %b in EMPTY, expected 0", eat_ack);
            end
        end
        eat_req = 1'b0;
        tick();
    endtask

    task automatic test_init();
        do_init(9'd300, 1'b0);
    endtask

    task automatic test_eat();
        do_eat(10'd40,  10'd70,  1'b1, 9'd299);
        do_eat(10'd40,  10'd70,  1'b0, 9'd299);
        do_eat(10'd5,   10'd5,   1'b1, 9'd298);
        do_eat(10'd639, 10'd479, 1'b1, 9'd297);
    endtask

    task automatic test_out_of_range();
        do_eat(10'd650,  10'd10,   1'b0, 9'd297);
        do_eat(10'd10,   10'd480,  1'b0, 9'd297);
        do_eat(10'd1023, 10'd1023, 1'b0, 9'd297);
    endtask

    task automatic test_render();
        logic [9:0]  hv [8][2];
        logic        bv [8];
        logic        ev [8];
        logic [11:0] exp_rgb;
        hv = '{'{10'd46, 10'd14}, '{10'd46, 10'd14}, '{10'd45, 10'd14}, '{10'd49, 10'd17},
               '{10'd50, 10'd14}, '{10'd46, 10'd78}, '{10'd46, 10'd110}, '{10'd654, 10'd14}};
        bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            hCount = hv[i][0];
            vCount = hv[i][1];
            bright = bv[i];
            tick();
            exp_rgb = ev[i] ? 12'hFF0 : 12'h000;
            checks++;
            if (pellet_pixel0 !== ev[i] || rgb0 !== exp_rgb) begin
                errors++;
                $display("FAIL render[%0d] (%0d,%0d,b=%b): got pixel=%b rgb=%h, expected pixel=%b rgb=%h",
                         i, hv[i][0], hv[i][1], bv[i], pellet_pixel0, rgb0, ev[i], exp_rgb);
            end
        end
        bright = 1'b0;
    endtask

    task automatic test_eat_during_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        eat_x = 10'd40; eat_y = 10'd70; eat_req = 1'b1;
        exp_q.push_back('{hit: 1'b1, rem: 9'd299});
        wait_init_then_ack("eat_in_init");
    endtask

    task automatic test_all_eaten();
        sel = 1'b1;
        do_init(9'd3, 1'b0);
        do_eat(10'd0,   10'd0,   1'b1, 9'd2);
        do_eat(10'd163, 10'd116, 1'b1, 9'd1);
        do_eat(10'd608, 10'd448, 1'b1, 9'd0);
        checks++;
        if (all_eaten !== 1'b1) begin
            errors++;
            $display("FAIL all_eaten: got %b, expected 1", all_eaten);
        end
        do_eat(10'd0, 10'd0, 1'b0, 9'd0);
        checks++;
        if (all_eaten !== 1'b1) begin
            errors++;
            $display("FAIL all_eaten_after_miss: got %b, expected 1", all_eaten);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        hCount = 10'd46; vCount = 10'd14; bright = 1'b1;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (8) tick();
        checks++;
        if (pellet_pixel0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_pixel: got %b before reset, expected 1", pellet_pixel0);
        end
        reset = 1'b1;
        #2;
        check_outputs_zero("reset_mid_init");
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (pellet_pixel0 !== 1'b0) begin
            errors++;
            $display("FAIL bitmap_after_reset: pixel %b, expected 0", pellet_pixel0);
        end
        bright = 1'b0;
        do_init(9'd300, 1'b0);
        do_eat(10'd40, 10'd70, 1'b1, 9'd299);
        eat_x = 10'd200; eat_y = 10'd200; eat_req = 1'b1; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        checks++;
        if (eat_ack !== 1'b0) begin
            errors++;
            $display("FAIL reload_wins_ack: got %b on reload cycle, expected 0", eat_ack);
        end
        exp_q.push_back('{hit: 1'b1, rem: 9'd299});
        wait_init_then_ack("reload_wins");
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; init_start = 1'b0; eat_req = 1'b0;
        eat_x = '0; eat_y = '0; hCount = '0; vCount = '0; bright = 1'b0;
        test_reset();
        test_init();
        test_eat();
        test_out_of_range();
        test_render();
        test_eat_during_init();
        test_all_eaten();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
